bru_issue_queue: RTL
====================

Name: bru_issue_queue

Overview:
- In-order issue queue for branch and jump ops, between dispatch/rename and the BRU operand-read/execute path.
- Buffers up to DEPTH ops and tracks readiness of two physical source tags per op using result wakeup broadcasts.
- Presents the oldest op to the BRU stage once both sources are ready, under a valid/allowin handshake.
- Branches resolve in program order, so issue is strictly from the head.

Parameters:
DEPTH, 8, queue entries (power of two, >=2)
PREG_W, 6, physical register tag width
WAKEUP_NUM, 4, number of wakeup broadcast ports
PAYLOAD_W, 128, opaque op payload (decoded op, pc, imm, rob entry, bpu entry, prediction)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline flush (mispredict/exception), synchronous
dispatch_valid  in  1  dispatch offers an op this cycle
biq_allowin  out  1  queue accepts dispatch this cycle
dispatch_payload  in  PAYLOAD_W  op payload
dispatch_src1_en  in  1  src1 is used
dispatch_src1_tag  in  PREG_W  src1 physical tag
dispatch_src1_ready  in  1  src1 already ready at rename
dispatch_src2_en  in  1  src2 is used
dispatch_src2_tag  in  PREG_W  src2 physical tag
dispatch_src2_ready  in  1  src2 already ready at rename
wakeup_valid  in  WAKEUP_NUM  per-port wakeup strobe
wakeup_tag  in  WAKEUP_NUM*PREG_W  per-port destination tag; port i in bits [i*PREG_W +: PREG_W]
issue_to_bru_valid  out  1  head op ready and offered
bru_allowin  in  1  downstream accepts
issue_payload  out  PAYLOAD_W  head payload
issue_src1_tag  out  PREG_W  head src1 tag (for regfile read)
issue_src2_tag  out  PREG_W  head src2 tag
biq_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH)+1 bits (wrap bit).
  - full = pointers equal except wrap bit; empty = pointers equal.
  - biq_count = tail - head, computed modulo 2^(log2(DEPTH)+1).
- biq_allowin = !full. It does not depend on bru_allowin or on a same-cycle pop: no dispatch when full, even if the head issues that cycle.
- Push: dispatch_valid && biq_allowin.
  - Writes the entry at tail; tail increments.
  - src ready bit = !en || dispatch_ready || (a same-cycle wakeup matches the tag).
- Wakeup: every cycle, each valid entry with a not-ready src whose tag equals any valid wakeup_tag sets that ready bit.
  - Ready bits are sticky until the entry is popped.
  - Tag 0 receives no special treatment.
- Issue (combinational from registered state):
  - issue_to_bru_valid = !empty && head src1_rdy && head src2_rdy.
  - A wakeup arriving this cycle does not make the head issue this cycle; it issues the next cycle.
  - issue_payload and issue_src*_tag always reflect the head entry, and are don't-care when empty.
- Pop: issue_to_bru_valid && bru_allowin; head increments.
  - While valid && !bru_allowin, the outputs hold stable.
- Simultaneous push and pop: both occur and biq_count is unchanged.
  - When the queue holds 1 entry, a push into an empty-after-pop slot is allowed only if not full before the cycle.
- Wrap-around: pointers wrap modulo DEPTH for indexing. The wrap bit distinguishes full from empty.
- Flush: next cycle head = tail = 0, all entries invalid, biq_count = 0.
  - Flush takes priority over a same-cycle push, pop, or wakeup; none of them take effect.
  - issue_to_bru_valid is 0 in the cycle after flush.
- Reset: same effect as flush.
  - Outputs after reset: biq_allowin = 1, issue_to_bru_valid = 0, biq_count = 0, issue_payload/tags = 0 (storage cleared).
- No combinational path from dispatch_* to any output.
- Wakeup-to-issue latency: 1 cycle. Dispatch-to-issue latency: minimum 1 cycle (an entry dispatched ready issues the next cycle).

Test Plan:
- After reset, dispatch 1 op with src1_en=src2_en=0, payload=0xA5, bru_allowin=1 -> next cycle issue_to_bru_valid=1, issue_payload=0xA5; the cycle after, count=0 and valid=0.
- Dispatch op with src1_tag=5 not ready, src2 unused. Drive wakeup_valid[2]=1, wakeup_tag[2]=5 in cycle 3 -> issue_to_bru_valid rises in cycle 4, not in cycle 3.
- In-order blocking: dispatch A (src tag 7 not ready), then B (ready) -> B never issues before A. Wake tag 7 -> A issues, then B on the next cycle.
- Fill 8 entries with bru_allowin=0:
  - biq_allowin=0 and biq_count=8; a 9th dispatch is ignored.
  - Raise bru_allowin -> 8 issues in FIFO order over 8 cycles, pointer wrap-around verified.
  - Refill works.
- Hold bru_allowin=0 with a ready head for 5 cycles -> issue_payload and tags stay stable, no pop.
- With 3 entries, assert flush together with dispatch_valid=1 and a pop -> next cycle count=0, valid=0, allowin=1; the dispatched op is absent.

Source files
------------

// File: rtl/bru_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : bru_issue_queue
// Purpose  : In-order issue queue for branch/jump ops. Buffers up to DEPTH
//            ops between rename and the BRU, tracks readiness of two physical
//            source tags per op via wakeup broadcasts, and offers the oldest
//            op once both of its sources are ready. Issue is strictly from
//            the head so branches resolve in program order.
// Ports    :
//   clk, reset, flush            clock, sync active-high reset, sync flush
//   dispatch_* / biq_allowin     dispatch-side valid/allowin handshake
//   wakeup_valid / wakeup_tag    WAKEUP_NUM result tag broadcasts (flattened)
//   issue_to_bru_valid /
//   bru_allowin                  issue-side valid/allowin handshake
//   issue_payload, issue_src*    head entry fields
//   biq_count                    occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module bru_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int PREG_W     = 6,
  parameter int WAKEUP_NUM = 4,
  parameter int PAYLOAD_W  = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         biq_allowin,
  input  logic [PAYLOAD_W-1:0]         dispatch_payload,
  input  logic                         dispatch_src1_en,
  input  logic [PREG_W-1:0]            dispatch_src1_tag,
  input  logic                         dispatch_src1_ready,
  input  logic                         dispatch_src2_en,
  input  logic [PREG_W-1:0]            dispatch_src2_tag,
  input  logic                         dispatch_src2_ready,
  input  logic [WAKEUP_NUM-1:0]        wakeup_valid,
  input  logic [WAKEUP_NUM*PREG_W-1:0] wakeup_tag,
  output logic                         issue_to_bru_valid,
  input  logic                         bru_allowin,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [PREG_W-1:0]            issue_src1_tag,
  output logic [PREG_W-1:0]            issue_src2_tag,
  output logic [$clog2(DEPTH):0]       biq_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [IDX_W-1:0]     head_idx;
  logic [IDX_W-1:0]     tail_idx;

  logic [PAYLOAD_W-1:0] payload_mem  [DEPTH];
  logic [PREG_W-1:0]    src1_tag_mem [DEPTH];
  logic [PREG_W-1:0]    src2_tag_mem [DEPTH];
  logic [DEPTH-1:0]     src1_rdy;
  logic [DEPTH-1:0]     src2_rdy;

  logic [DEPTH-1:0]     src1_hit;
  logic [DEPTH-1:0]     src2_hit;
  logic                 disp_src1_hit;
  logic                 disp_src2_hit;

  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;

  // True when any valid broadcast port carries the given tag.
  function automatic logic wake_hit(
    input logic [PREG_W-1:0]            tag,
    input logic [WAKEUP_NUM-1:0]        wv,
    input logic [WAKEUP_NUM*PREG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKEUP_NUM; p++) begin
      if (wv[p] && (wt[p*PREG_W +: PREG_W] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  assign empty = (head == tail);
  assign full  = (head[IDX_W] != tail[IDX_W]) && (head_idx == tail_idx);

  // Modulo 2^PTR_W subtraction yields occupancy directly, including DEPTH.
  assign biq_count = tail - head;

  // Allowin deliberately ignores a same-cycle pop to keep dispatch off the
  // issue-side timing path.
  assign biq_allowin = !full;
  assign push        = dispatch_valid && !full;

  // Issue reads registered state only; a wakeup this cycle shows up next cycle.
  assign issue_to_bru_valid = !empty && src1_rdy[head_idx] && src2_rdy[head_idx];
  assign pop                = issue_to_bru_valid && bru_allowin;

  assign issue_payload  = payload_mem[head_idx];
  assign issue_src1_tag = src1_tag_mem[head_idx];
  assign issue_src2_tag = src2_tag_mem[head_idx];

  assign disp_src1_hit = wake_hit(dispatch_src1_tag, wakeup_valid, wakeup_tag);
  assign disp_src2_hit = wake_hit(dispatch_src2_tag, wakeup_valid, wakeup_tag);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign src1_hit[i] = wake_hit(src1_tag_mem[i], wakeup_valid, wakeup_tag);
      assign src2_hit[i] = wake_hit(src2_tag_mem[i], wakeup_valid, wakeup_tag);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head     <= '0;
      tail     <= '0;
      src1_rdy <= '0;
      src2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_mem[i]  <= '0;
        src1_tag_mem[i] <= '0;
        src2_tag_mem[i] <= '0;
      end
    end else begin
      // Sticky wakeup; stale entries may also set bits, which is harmless
      // because a push rewrites both bits of its slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (src1_hit[i]) src1_rdy[i] <= 1'b1;
        if (src2_hit[i]) src2_rdy[i] <= 1'b1;
      end

      if (push) begin
        payload_mem[tail_idx]  <= dispatch_payload;
        src1_tag_mem[tail_idx] <= dispatch_src1_tag;
        src2_tag_mem[tail_idx] <= dispatch_src2_tag;
        src1_rdy[tail_idx]     <= !dispatch_src1_en || dispatch_src1_ready || disp_src1_hit;
        src2_rdy[tail_idx]     <= !dispatch_src2_en || dispatch_src2_ready || disp_src2_hit;
        tail                   <= tail + PTR_ONE;
      end

      if (pop) begin
        head <= head + PTR_ONE;
      end
    end
  end

endmodule
`default_nettype wire
